// File: rtl/wb_pkg.sv
// Shared types for the writeback stage.
//   wb_state_t  - sequencing FSM states
//   wb_bundle_t - Execute result fields latched on accept
//   REG_RDX     - architectural register that receives the MUL/IMUL high half
//   first_step  - picks the next side-effect state from the pending-step flags
package wb_pkg;

    localparam int unsigned WB_DATA_W     = 64;
    localparam int unsigned WB_REG_ADDR_W = 4;

    localparam logic [WB_REG_ADDR_W-1:0] REG_RDX = 4'd2;

    typedef enum logic [2:0] {
        StIdle,
        StMemWait,
        StWrDest,
        StWrSpecial,
        StHalted
    } wb_state_t;

    typedef struct packed {
        logic                     kill;
        logic [WB_DATA_W-1:0]     alu_result;
        logic [WB_DATA_W-1:0]     alu_result_special;
        logic [WB_REG_ADDR_W-1:0] dest_reg;
        logic                     dest_reg_valid;
        logic [WB_REG_ADDR_W-1:0] dest_reg_special;
        logic                     dest_reg_special_valid;
        logic                     is_mem_dest;
        logic [WB_DATA_W-1:0]     mem_addr;
        logic [WB_DATA_W-1:0]     rip;
    } wb_bundle_t;

    // Side effects run in the fixed order store -> dest reg -> special reg.
    // StIdle is returned when nothing remains, meaning "retire now".
    function automatic wb_state_t first_step(input logic mem, input logic dest_v,
                                             input logic spec_v);
        wb_state_t st;
        if (mem) begin
            st = StMemWait;
        end else if (dest_v) begin
            st = StWrDest;
        end else if (spec_v) begin
            st = StWrSpecial;
        end else begin
            st = StIdle;
        end
        return st;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Execute -> Writeback result bundle and the stall returned to Execute.
//   master : Execute side (drives the bundle, observes wbStallOut)
//   slave  : Writeback side (samples the bundle, drives wbStallOut)
interface writeback_stage_if #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_ADDR_W = 4
);
    logic                  isExecuteSuccessfulIn;
    logic                  killIn;
    logic [DATA_W-1:0]     aluResultIn;
    logic [DATA_W-1:0]     aluResultSpecialIn;
    logic [REG_ADDR_W-1:0] destRegIn;
    logic                  destRegValidIn;
    logic [REG_ADDR_W-1:0] destRegSpecialIn;
    logic                  destRegSpecialValidIn;
    logic                  isMemoryAccessDestIn;
    logic [DATA_W-1:0]     memoryAddressDestIn;
    logic [DATA_W-1:0]     currentRipIn;
    logic                  wbStallOut;

    modport master (
        output isExecuteSuccessfulIn, killIn, aluResultIn, aluResultSpecialIn, destRegIn,
               destRegValidIn, destRegSpecialIn, destRegSpecialValidIn, isMemoryAccessDestIn,
               memoryAddressDestIn, currentRipIn,
        input  wbStallOut
    );

    modport slave (
        input  isExecuteSuccessfulIn, killIn, aluResultIn, aluResultSpecialIn, destRegIn,
               destRegValidIn, destRegSpecialIn, destRegSpecialValidIn, isMemoryAccessDestIn,
               memoryAddressDestIn, currentRipIn,
        output wbStallOut
    );

endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: accepts one Execute bundle in IDLE, then sequences its side
// effects (memory store, destination register write, special register write),
// retires it and optionally halts the core on a kill instruction.
// Ports:
//   clk, resetN          - clock, asynchronous active-low reset
//   ex_if (slave)        - Execute result bundle in, wbStallOut back to Execute
//   regWrite*Out         - register-file write port
//   memWrite*Out/AckIn   - store request with ack handshake
//   retireOut/RipOut     - one-cycle retire pulse and RIP of the retired instruction
//   retireCountOut       - running retired-instruction count (wraps)
//   haltOut              - core halted, cleared only by reset
// DATA_W / REG_ADDR_W must match the widths of wb_pkg::wb_bundle_t.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W       = WB_DATA_W,
    parameter int unsigned REG_ADDR_W   = WB_REG_ADDR_W,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    resetN,
    writeback_stage_if.slave        ex_if,
    output logic                    regWriteEnOut,
    output logic [REG_ADDR_W-1:0]   regWriteAddrOut,
    output logic [DATA_W-1:0]       regWriteDataOut,
    output logic                    memWriteReqOut,
    output logic [DATA_W-1:0]       memWriteAddrOut,
    output logic [DATA_W-1:0]       memWriteDataOut,
    input  logic                    memWriteAckIn,
    output logic                    retireOut,
    output logic [DATA_W-1:0]       retireRipOut,
    output logic [RETIRE_CNT_W-1:0] retireCountOut,
    output logic                    haltOut
);

    wb_state_t               state_q, state_d;
    wb_bundle_t              bundle_q, bundle_d;
    logic                    retire_q, retire_d;
    logic [DATA_W-1:0]       retire_rip_q, retire_rip_d;
    logic [RETIRE_CNT_W-1:0] retire_count_q, retire_count_d;

    // Scratch signals for the terminal decision.
    logic              finish;
    logic              fin_kill;
    logic [DATA_W-1:0] fin_rip;
    wb_state_t         nxt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= StIdle;
            bundle_q       <= '0;
            retire_q       <= 1'b0;
            retire_rip_q   <= '0;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            bundle_q       <= bundle_d;
            retire_q       <= retire_d;
            retire_rip_q   <= retire_rip_d;
            retire_count_q <= retire_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bundle_d       = bundle_q;
        retire_d       = 1'b0;
        retire_rip_d   = retire_rip_q;
        retire_count_d = retire_count_q;
        finish         = 1'b0;
        fin_kill       = bundle_q.kill;
        fin_rip        = bundle_q.rip;
        nxt            = StIdle;

        case (state_q)
            StIdle: begin
                if (ex_if.isExecuteSuccessfulIn) begin
                    bundle_d.kill                   = ex_if.killIn;
                    bundle_d.alu_result             = ex_if.aluResultIn;
                    bundle_d.alu_result_special     = ex_if.aluResultSpecialIn;
                    bundle_d.dest_reg               = ex_if.destRegIn;
                    bundle_d.dest_reg_valid         = ex_if.destRegValidIn;
                    bundle_d.dest_reg_special       = ex_if.destRegSpecialIn;
                    bundle_d.dest_reg_special_valid = ex_if.destRegSpecialValidIn;
                    bundle_d.is_mem_dest            = ex_if.isMemoryAccessDestIn;
                    bundle_d.mem_addr               = ex_if.memoryAddressDestIn;
                    bundle_d.rip                    = ex_if.currentRipIn;
                    // Zero-step instructions retire straight off the accept edge, so
                    // kill/RIP must come from the inputs rather than the latch.
                    fin_kill = ex_if.killIn;
                    fin_rip  = ex_if.currentRipIn;
                    nxt = first_step(ex_if.isMemoryAccessDestIn, ex_if.destRegValidIn,
                                     ex_if.destRegSpecialValidIn);
                    if (nxt == StIdle) begin
                        finish = 1'b1;
                    end else begin
                        state_d = nxt;
                    end
                end
            end
            StMemWait: begin
                if (memWriteAckIn) begin
                    nxt = first_step(1'b0, bundle_q.dest_reg_valid,
                                     bundle_q.dest_reg_special_valid);
                    if (nxt == StIdle) begin
                        finish = 1'b1;
                    end else begin
                        state_d = nxt;
                    end
                end
            end
            StWrDest: begin
                nxt = first_step(1'b0, 1'b0, bundle_q.dest_reg_special_valid);
                if (nxt == StIdle) begin
                    finish = 1'b1;
                end else begin
                    state_d = nxt;
                end
            end
            StWrSpecial: begin
                finish = 1'b1;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            retire_d       = 1'b1;
            retire_rip_d   = fin_rip;
            retire_count_d = retire_count_q + RETIRE_CNT_W'(1);
            state_d        = fin_kill ? StHalted : StIdle;
        end
    end

    // Outputs decode from state only, so an asynchronous reset drops them at once.
    always_comb begin
        regWriteEnOut   = 1'b0;
        regWriteAddrOut = '0;
        regWriteDataOut = '0;
        memWriteReqOut  = 1'b0;
        memWriteAddrOut = '0;
        memWriteDataOut = '0;
        case (state_q)
            StMemWait: begin
                memWriteReqOut  = 1'b1;
                memWriteAddrOut = bundle_q.mem_addr;
                memWriteDataOut = bundle_q.alu_result;
            end
            StWrDest: begin
                regWriteEnOut   = 1'b1;
                regWriteAddrOut = bundle_q.dest_reg;
                regWriteDataOut = bundle_q.alu_result;
            end
            StWrSpecial: begin
                regWriteEnOut   = 1'b1;
                regWriteAddrOut = bundle_q.dest_reg_special;
                regWriteDataOut = bundle_q.alu_result_special;
            end
            default: begin
            end
        endcase
    end

    assign ex_if.wbStallOut = (state_q != StIdle);
    assign haltOut          = (state_q == StHalted);
    assign retireOut        = retire_q;
    assign retireRipOut     = retire_rip_q;
    assign retireCountOut   = retire_count_q;

endmodule
